branch_resolve: RTL

- Downstream consumer of the registered condition flags (negative, overflow, zero, carry_out) in the pipelined LEGv8 datapath.
- Resolves B.cond, CBZ and B in the EX/MEM boundary and computes the branch target.
- Forwards the live ALU flags when the instruction immediately ahead is updating the flags.
- Registers the redirect, then sequences a fixed-length front-end flush.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/cond_eval.sv | 33 +++
 rtl/branch_resolve.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types for the EX/MEM branch resolver: condition codes, FSM states
// and the NZCV flag bundle.
package branch_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of an ARM/LEGv8 condition code against NZCV.
module cond_eval
  import branch_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = flags.z;
      COND_NE: cond_true = !flags.z;
      COND_HS: cond_true = flags.c;
      COND_LO: cond_true = !flags.c;
      COND_MI: cond_true = flags.n;
      COND_PL: cond_true = !flags.n;
      COND_VS: cond_true = flags.v;
      COND_VC: cond_true = !flags.v;
      COND_HI: cond_true = flags.c & !flags.z;
      COND_LS: cond_true = !(flags.c & !flags.z);
      COND_GE: cond_true = (flags.n == flags.v);
      COND_LT: cond_true = (flags.n != flags.v);
      COND_GT: cond_true = !flags.z & (flags.n == flags.v);
      COND_LE: cond_true = !(!flags.z & (flags.n == flags.v));
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver: decides B.cond/CBZ/B, registers the redirect and runs a
// fixed-length front-end flush. Define BRANCH_STATS_EN for branch counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              valid_in,
  input  logic              is_bcond,
  input  logic              is_cbz,
  input  logic              is_uncond,
  input  logic [3:0]        cond,
  input  logic              reg_zero,
  input  logic              flag_wr,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_carry_out,
  input  logic              negative,
  input  logic              overflow,
  input  logic              zero,
  input  logic              carry_out,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              take_branch,
  output logic [ADDR_W-1:0] branch_target,
  output logic              flush,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  br_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              take_q, take_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] target_q, target_d;

  flags_t            sel_flags;
  logic              cond_true;
  logic              taken;
  logic [ADDR_W-1:0] target;

  // The older instruction's flags are not registered yet when it writes them.
  assign sel_flags = flag_wr ? '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow}
                             : '{n: negative, z: zero, c: carry_out, v: overflow};

  cond_eval u_cond_eval (
    .cond      (cond_e'(cond)),
    .flags     (sel_flags),
    .cond_true (cond_true)
  );

  assign target = pc_in + br_offset;

  always_comb begin
    taken = 1'b0;
    if (valid_in) begin
      if (is_uncond)     taken = 1'b1;
      else if (is_cbz)   taken = reg_zero;
      else if (is_bcond) taken = cond_true;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    take_d   = take_q;
    flush_d  = flush_q;
    target_d = target_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          take_d  = taken;
          flush_d = taken;
          if (taken) begin
            target_d = target;
            cnt_d    = CNT_INIT;
            state_d  = FLUSH;
          end
        end
        FLUSH: begin
          take_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = IDLE;
            flush_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          flush_d = 1'b0;
          take_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      take_q   <= 1'b0;
      flush_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      take_q   <= take_d;
      flush_q  <= flush_d;
      target_q <= target_d;
    end
  end

  assign take_branch   = take_q;
  assign branch_target = target_q;
  assign flush         = flush_q;
  assign busy          = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
  logic any_sel;
  assign any_sel = valid_in & (is_bcond | is_cbz | is_uncond);

  always_ff @(posedge clk) begin
    if (reset) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (!stall && state_q == IDLE) begin
      if (any_sel && br_count != '1)  br_count    <= br_count + CNT_W'(1);
      if (taken && taken_count != '1) taken_count <= taken_count + CNT_W'(1);
    end
  end
`endif

endmodule
